// File: rtl/formula_1_isqrt_seq.sv
// formula_1_isqrt_seq: res = isqrt(a) + isqrt(b) + isqrt(c) using one shared external pipelined isqrt unit
// Ports:
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_arg_vld/o_arg_rdy argument handshake for i_a, i_b, i_c
//   o_isqrt_x_vld/x     operand stream into the shared isqrt pipe
//   i_isqrt_y_vld/y     root stream returning from the isqrt pipe
//   o_res_vld/o_res     one-cycle result pulse, res holds until next completion
module formula_1_isqrt_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arg_vld,
    output logic             o_arg_rdy,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic             o_isqrt_x_vld,
    output logic [WIDTH-1:0] o_isqrt_x,
    input  logic             i_isqrt_y_vld,
    input  logic [WIDTH-1:0] i_isqrt_y,
    output logic             o_res_vld,
    output logic [WIDTH-1:0] o_res
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    state_t           r_state;
    logic [1:0]       r_idx;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_acc;
    logic             r_x_vld;
    logic [WIDTH-1:0] r_x;
    logic             r_res_vld;
    logic [WIDTH-1:0] r_res;
    logic             w_col;
    logic [WIDTH-1:0] w_sum;
    // returns are collected while issuing too, so latency-1 pipes work
    assign w_col         = i_isqrt_y_vld && r_state != S_IDLE;
    assign w_sum         = r_acc + i_isqrt_y;
    assign o_arg_rdy     = r_state == S_IDLE;
    assign o_isqrt_x_vld = r_x_vld;
    assign o_isqrt_x     = r_x;
    assign o_res_vld     = r_res_vld;
    assign o_res         = r_res;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_x_vld   <= 1'b0;
            r_x       <= '0;
            r_res_vld <= 1'b0;
            r_res     <= '0;
        end else begin
            r_res_vld <= 1'b0;
            case (r_state)
                S_IDLE: if (i_arg_vld) begin
                    // a goes straight to the pipe; b and c wait in registers
                    r_b     <= i_b;
                    r_c     <= i_c;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_x_vld <= 1'b1;
                    r_x     <= i_a;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_idx   <= r_idx + 2'd1;
                    r_x_vld <= r_idx != 2'd2;
                    r_x     <= r_idx == 2'd0 ? r_b : r_idx == 2'd1 ? r_c : r_x;
                    r_state <= r_idx == 2'd2 ? S_WAIT : S_ISSUE;
                end
                default: ;
            endcase
            if (w_col) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd2) begin
                    r_res     <= w_sum;
                    r_res_vld <= 1'b1;
                    r_state   <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_formula_1_isqrt_seq.sv
// tb_formula_1_isqrt_seq: randomized and directed checks of formula_1_isqrt_seq against a behavioural model
module tb_formula_1_isqrt_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arg_vld = 1'b0;
    logic        inj = 1'b0;
    logic        arg_rdy, x_vld, y_vld, res_vld;
    logic [31:0] a = '0, b = '0, c = '0;
    logic [31:0] x, y, res;
    int          lat = 4, errors = 0, checks = 0, cyc = 0, done_cyc = 0;
    logic        pv [16];
    logic [31:0] pd [16];
    logic [31:0] xq [$], rq [$];
    int          xc [$], rc [$];
    logic [31:0] last_x = '0, last_res = '0;
    logic        ex, er;

    always #5 clk = ~clk;

    formula_1_isqrt_seq #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_arg_vld(arg_vld), .o_arg_rdy(arg_rdy),
        .i_a(a), .i_b(b), .i_c(c),
        .o_isqrt_x_vld(x_vld), .o_isqrt_x(x),
        .i_isqrt_y_vld(y_vld), .i_isqrt_y(y),
        .o_res_vld(res_vld), .o_res(res)
    );

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        longint lo = 0, hi = 65536, m;
        while (hi - lo > 1) begin
            m = (lo + hi) / 2;
            if (m * m <= longint'(v)) lo = m; else hi = m;
        end
        return 32'(lo);
    endfunction

    function automatic logic [31:0] rv();
        int k = $urandom_range(0, 3);
        return k == 0 ? 32'd0 : k == 1 ? 32'hFFFF_FFFF : 32'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // shared isqrt unit of latency lat, flushed by the common reset
    assign y_vld = inj | pv[lat-1];
    assign y     = inj ? 32'd7 : pd[lat-1];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= x_vld;
            pd[0] <= isqrt(x);
            for (int i = 1; i < 16; i++) begin
                pv[i] <= i < lat ? pv[i-1] : 1'b0;
                pd[i] <= pd[i-1];
            end
        end
    end

    // cycle-accurate expectation of every output, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            xq.delete(); xc.delete(); rq.delete(); rc.delete();
            done_cyc = 0; last_x = '0; last_res = '0;
        end else begin
            chk("arg_rdy", 32'(arg_rdy), 32'(cyc >= done_cyc));
            ex = xc.size() > 0 && xc[0] == cyc;
            chk("x_vld", 32'(x_vld), 32'(ex));
            if (ex) begin
                last_x = xq.pop_front();
                void'(xc.pop_front());
            end
            chk("x", x, last_x);
            er = rc.size() > 0 && rc[0] == cyc;
            chk("res_vld", 32'(res_vld), 32'(er));
            if (er) begin
                last_res = rq.pop_front();
                void'(rc.pop_front());
            end
            chk("res", res, last_res);
            if (arg_vld && cyc >= done_cyc) begin
                xq.push_back(a); xq.push_back(b); xq.push_back(c);
                xc.push_back(cyc + 1); xc.push_back(cyc + 2); xc.push_back(cyc + 3);
                rq.push_back(isqrt(a) + isqrt(b) + isqrt(c));
                rc.push_back(cyc + 4 + lat);
                done_cyc = cyc + 4 + lat;
            end
        end
    end

    task automatic send(input logic [31:0] na, input logic [31:0] nb, input logic [31:0] nc, input bit keep = 1'b0);
        @(posedge clk); #1;
        arg_vld = 1'b1; a = na; b = nb; c = nc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arg_rdy) break;
        end
        chk("accept", 32'(arg_rdy), 32'd1);
        if (!keep) begin
            @(posedge clk); #1;
            arg_vld = 1'b0;
        end
    endtask

    task automatic wait_res(input string tag, input logic [31:0] exp, output int n);
        n = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_vld) begin
                n = i;
                break;
            end
        end
        chk({tag, "_vld"}, 32'(res_vld), 32'd1);
        chk(tag, res, exp);
    endtask

    initial begin
        int n, k;
        logic [31:0] ra, rb, rcv;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(arg_rdy), 32'd1);
        chk("rst_xvld", 32'(x_vld), 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_rvld", 32'(res_vld), 32'd0);
        chk("rst_res", res, 32'd0);
        lat = 4;
        send(16, 9, 4);
        wait_res("basic", 9, n);
        chk("basic_lat", 32'(n), 32'(lat + 3));
        chk("basic_rdy", 32'(arg_rdy), 32'd1);
        send(15, 0, 32'hFFFF_FFFF);
        wait_res("floor", 65538, n);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_res("max", 196605, n);
        send(1, 1, 1, 1'b1);
        send(100, 25, 36, 1'b1);
        chk("b2b_first_vld", 32'(res_vld), 32'd1);
        chk("b2b_first", res, 3);
        @(posedge clk); #1 arg_vld = 1'b0;
        wait_res("b2b_second", 21, n);
        chk("b2b_lat", 32'(n), 32'(lat + 3));
        send(5, 6, 7);
        @(posedge clk); #1 arg_vld = 1'b1; a = 999; b = 999; c = 999;
        @(posedge clk); #1 arg_vld = 1'b0;
        @(posedge clk); #1 arg_vld = 1'b1;
        @(posedge clk); #1 arg_vld = 1'b0;
        wait_res("busy", 6, n);
        @(posedge clk); #1 inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        repeat (3) @(posedge clk);
        send(16, 9, 4);
        wait_res("stray_y", 9, n);
        lat = 1;
        send(64, 49, 1);
        wait_res("lat1", 16, n);
        chk("lat1_cyc", 32'(n), 32'd4);
        lat = 12;
        send(64, 49, 1);
        wait_res("lat12", 16, n);
        chk("lat12_cyc", 32'(n), 32'd15);
        send(64, 49, 1);
        k = 0;
        for (int i = 0; i < 200 && k < 2; i++) begin
            @(negedge clk);
            if (y_vld) k++;
        end
        chk("two_returns", 32'(k), 32'd2);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", 32'(arg_rdy), 32'd1);
        chk("mid_rst_xvld", 32'(x_vld), 32'd0);
        chk("mid_rst_x", x, 32'd0);
        chk("mid_rst_rvld", 32'(res_vld), 32'd0);
        chk("mid_rst_res", res, 32'd0);
        send(4, 4, 4);
        wait_res("after_rst", 6, n);
        for (int t = 0; t < 40; t++) begin
            lat = $urandom_range(1, 12);
            ra = rv(); rb = rv(); rcv = rv();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(ra, rb, rcv);
            wait_res("rand", isqrt(ra) + isqrt(rb) + isqrt(rcv), n);
            chk("rand_cyc", 32'(n), 32'(lat + 3));
        end
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
